// File: rtl/midi_note_stack.sv
// midi_note_stack: last-note-priority mono note stack with per-note velocity.
// Stage 1 registers and decodes a received MIDI message; stage 2 updates the stack
// and the registered synth/display outputs.
// Build option: define NOTE_STACK_OMNI_EN to accept messages on all 16 channels.

// Hex digit to active-low 7-segment pattern (bit 7 = decimal point, kept off).
module LEDDecoder (
    input  logic [3:0] digit,
    input  logic       enable,
    output logic [7:0] n_seg_c
);

    // Segment lookup; blank when disabled
    always_comb begin
        n_seg_c = 8'hFF;
        if (enable) begin
            case (digit)
                4'h0: n_seg_c = 8'hC0;
                4'h1: n_seg_c = 8'hF9;
                4'h2: n_seg_c = 8'hA4;
                4'h3: n_seg_c = 8'hB0;
                4'h4: n_seg_c = 8'h99;
                4'h5: n_seg_c = 8'h92;
                4'h6: n_seg_c = 8'h82;
                4'h7: n_seg_c = 8'hF8;
                4'h8: n_seg_c = 8'h80;
                4'h9: n_seg_c = 8'h90;
                4'hA: n_seg_c = 8'h88;
                4'hB: n_seg_c = 8'h83;
                4'hC: n_seg_c = 8'hC6;
                4'hD: n_seg_c = 8'hA1;
                4'hE: n_seg_c = 8'h86;
                default: n_seg_c = 8'h8E;
            endcase
        end
    end

endmodule

module midi_note_stack #(
    parameter int unsigned VOICES  = 4,
    parameter int unsigned CHANNEL = 0
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [7:0]                   MIDI_STATUS,
    input  logic [7:0]                   MIDI_DATA1,
    input  logic [7:0]                   MIDI_DATA2,
    input  logic                         MIDI_MSG_RDY,
    output logic [6:0]                   NOTE,
    output logic [6:0]                   VELOCITY,
    output logic                         GATE,
    output logic                         RETRIG,
    output logic [$clog2(VOICES+1)-1:0]  COUNT,
    output logic [7:0]                   nHEX0,
    output logic [7:0]                   nHEX1
);

    localparam int unsigned CW = $clog2(VOICES + 1);

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_ON   = 2'd1;
    localparam logic [1:0] K_OFF  = 2'd2;
    localparam logic [1:0] K_CLR  = 2'd3;

    logic          chan_ok_c;
    logic [1:0]    kind_c;
    logic [1:0]    s1_kind;
    logic [6:0]    s1_note;
    logic [6:0]    s1_vel;

    logic [6:0]    stk_note [VOICES];
    logic [6:0]    stk_vel  [VOICES];
    logic [6:0]    note_n   [VOICES];
    logic [6:0]    vel_n    [VOICES];
    logic [CW-1:0] count_n;
    logic          hit_c;
    int            hit_idx_c;
    logic          gate_n;
    logic [6:0]    top_note_n;
    logic [6:0]    top_vel_n;
    logic          retrig_n;
    logic [7:0]    hex0_c;
    logic [7:0]    hex1_c;

    // Message filter and classification
    always_comb begin
        kind_c = K_NONE;
`ifdef NOTE_STACK_OMNI_EN
        chan_ok_c = 1'b1;
`else
        chan_ok_c = (MIDI_STATUS[3:0] == 4'(CHANNEL));
`endif
        if (MIDI_MSG_RDY && chan_ok_c && !MIDI_DATA1[7] && !MIDI_DATA2[7]) begin
            case (MIDI_STATUS[7:4])
                4'h9: kind_c = (MIDI_DATA2 != 8'h00) ? K_ON : K_OFF;
                4'h8: kind_c = K_OFF;
                4'hB: if (MIDI_DATA1 == 8'h7B || MIDI_DATA1 == 8'h78) kind_c = K_CLR;
                default: kind_c = K_NONE;
            endcase
        end
    end

    // Stage 1: capture decoded message
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_kind <= K_NONE;
            s1_note <= '0;
            s1_vel  <= '0;
        end else begin
            s1_kind <= kind_c;
            s1_note <= MIDI_DATA1[6:0];
            s1_vel  <= MIDI_DATA2[6:0];
        end
    end

    // Stage 2 next-state: stack edit, count, top-of-stack and retrigger
    always_comb begin
        note_n    = stk_note;
        vel_n     = stk_vel;
        count_n   = COUNT;
        hit_c     = 1'b0;
        hit_idx_c = 0;
        for (int i = 0; i < VOICES; i++) begin
            if (!hit_c && CW'(i) < COUNT && stk_note[i] == s1_note) begin
                hit_c     = 1'b1;
                hit_idx_c = i;
            end
        end
        case (s1_kind)
            K_ON: begin
                // Push to top; an existing copy is pulled out, else the oldest falls off
                note_n[0] = s1_note;
                vel_n[0]  = s1_vel;
                for (int i = 1; i < VOICES; i++) begin
                    if (!hit_c || i <= hit_idx_c) begin
                        note_n[i] = stk_note[i-1];
                        vel_n[i]  = stk_vel[i-1];
                    end
                end
                if (!hit_c && COUNT != CW'(VOICES)) count_n = COUNT + CW'(1);
            end
            K_OFF: begin
                // Close the gap left by the released note
                if (hit_c) begin
                    for (int i = 0; i < VOICES - 1; i++) begin
                        if (i >= hit_idx_c) begin
                            note_n[i] = stk_note[i+1];
                            vel_n[i]  = stk_vel[i+1];
                        end
                    end
                    note_n[VOICES-1] = '0;
                    vel_n[VOICES-1]  = '0;
                    count_n          = COUNT - CW'(1);
                end
            end
            K_CLR: begin
                for (int i = 0; i < VOICES; i++) begin
                    note_n[i] = '0;
                    vel_n[i]  = '0;
                end
                count_n = '0;
            end
            default: ;
        endcase
        gate_n     = (count_n != '0);
        top_note_n = gate_n ? note_n[0] : 7'd0;
        top_vel_n  = gate_n ? vel_n[0]  : 7'd0;
        retrig_n   = (s1_kind != K_NONE) && gate_n && (!GATE || top_note_n != NOTE);
    end

    LEDDecoder u_hex0 (
        .digit   (top_note_n[3:0]),
        .enable  (gate_n),
        .n_seg_c (hex0_c)
    );

    LEDDecoder u_hex1 (
        .digit   ({1'b0, top_note_n[6:4]}),
        .enable  (gate_n),
        .n_seg_c (hex1_c)
    );

    // Stage 2 registers: stack contents and all outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < VOICES; i++) begin
                stk_note[i] <= '0;
                stk_vel[i]  <= '0;
            end
            COUNT    <= '0;
            NOTE     <= '0;
            VELOCITY <= '0;
            GATE     <= 1'b0;
            RETRIG   <= 1'b0;
            nHEX0    <= 8'hFF;
            nHEX1    <= 8'hFF;
        end else begin
            stk_note <= note_n;
            stk_vel  <= vel_n;
            COUNT    <= count_n;
            NOTE     <= top_note_n;
            VELOCITY <= top_vel_n;
            GATE     <= gate_n;
            RETRIG   <= retrig_n;
            nHEX0    <= hex0_c;
            nHEX1    <= hex1_c;
        end
    end

endmodule

// File: tb/tb_midi_note_stack.sv
// Scoreboard bench for midi_note_stack (VOICES=4, CHANNEL=0).
// Each issued message pushes its expected output snapshot, due two edges later;
// a negedge monitor pops and compares, and checks RETRIG is quiet otherwise.
module tb_midi_note_stack;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [7:0] MIDI_STATUS = 8'h00;
    logic [7:0] MIDI_DATA1 = 8'h00;
    logic [7:0] MIDI_DATA2 = 8'h00;
    logic       MIDI_MSG_RDY = 1'b0;
    logic [6:0] NOTE;
    logic [6:0] VELOCITY;
    logic       GATE;
    logic       RETRIG;
    logic [2:0] COUNT;
    logic [7:0] nHEX0;
    logic [7:0] nHEX1;

    midi_note_stack #(.VOICES(4), .CHANNEL(0)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .MIDI_STATUS  (MIDI_STATUS),
        .MIDI_DATA1   (MIDI_DATA1),
        .MIDI_DATA2   (MIDI_DATA2),
        .MIDI_MSG_RDY (MIDI_MSG_RDY),
        .NOTE         (NOTE),
        .VELOCITY     (VELOCITY),
        .GATE         (GATE),
        .RETRIG       (RETRIG),
        .COUNT        (COUNT),
        .nHEX0        (nHEX0),
        .nHEX1        (nHEX1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int           due;
        logic [6:0]   note;
        logic [6:0]   vel;
        logic         gate;
        logic         rt;
        logic [2:0]   cnt;
        logic [127:0] nm;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[d];
    endfunction

    // Monitor: compare the due snapshot, else require RETRIG low
    initial begin
        exp_t       e;
        logic [7:0] h0;
        logic [7:0] h1;
        logic [42:0] act;
        logic [42:0] req;
        forever begin
            @(negedge CLK);
            while (sbq.size() != 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL %0s: snapshot missed (due %0d, now %0d)", e.nm, e.due, cyc);
            end
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e   = sbq.pop_front();
                h0  = e.gate ? seg7(e.note[3:0]) : 8'hFF;
                h1  = e.gate ? seg7({1'b0, e.note[6:4]}) : 8'hFF;
                act = {NOTE, VELOCITY, GATE, RETRIG, COUNT, nHEX0, nHEX1};
                req = {e.note, e.vel, e.gate, e.rt, e.cnt, h0, h1};
                n_vec++;
                if (act !== req) begin
                    n_err++;
                    $display("FAIL %0s: got note=%0d vel=%0d gate=%b rt=%b cnt=%0d hex=%h/%h, want note=%0d vel=%0d gate=%b rt=%b cnt=%0d hex=%h/%h",
                             e.nm, NOTE, VELOCITY, GATE, RETRIG, COUNT, nHEX0, nHEX1,
                             e.note, e.vel, e.gate, e.rt, e.cnt, h0, h1);
                end
            end else begin
                n_vec++;
                if (RETRIG !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_retrig: got RETRIG=%b at cycle %0d, want 0", RETRIG, cyc);
                end
            end
        end
    end

    task automatic push(input int due, input logic [6:0] en, input logic [6:0] ev,
                        input logic eg, input logic ert, input logic [2:0] ec,
                        input logic [127:0] nm);
        exp_t e;
        e.due = due; e.note = en; e.vel = ev; e.gate = eg; e.rt = ert; e.cnt = ec; e.nm = nm;
        sbq.push_back(e);
    endtask

    // Drive one strobe cycle and schedule its expected result two edges later
    task automatic send(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [6:0] en, input logic [6:0] ev, input logic eg,
                        input logic ert, input logic [2:0] ec, input logic [127:0] nm);
        @(posedge CLK); #1;
        MIDI_STATUS  = st;
        MIDI_DATA1   = d1;
        MIDI_DATA2   = d2;
        MIDI_MSG_RDY = 1'b1;
        push(cyc + 2, en, ev, eg, ert, ec, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            MIDI_MSG_RDY = 1'b0;
        end
    endtask

    task automatic msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [6:0] en, input logic [6:0] ev, input logic eg,
                       input logic ert, input logic [2:0] ec, input logic [127:0] nm);
        send(st, d1, d2, en, ev, eg, ert, ec, nm);
        idle(3);
    endtask

    task automatic drain();
        int budget = 20;
        while (sbq.size() != 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d snapshots still pending, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        push(cyc, 7'd0, 7'd0, 1'b0, 1'b0, 3'd0, "reset_state");
        idle(2);

        // Basic on/off with retrigger
        msg(8'h90, 8'd60, 8'd100, 7'd60, 7'd100, 1, 1, 3'd1, "on60");
        msg(8'h90, 8'd64, 8'd80,  7'd64, 7'd80,  1, 1, 3'd2, "on64");
        msg(8'h80, 8'd64, 8'd0,   7'd60, 7'd100, 1, 1, 3'd1, "off64");
        msg(8'h80, 8'd60, 8'd0,   7'd0,  7'd0,   0, 0, 3'd0, "off60_empty");

        // Overflow drops the oldest entry
        msg(8'h90, 8'd60, 8'd10, 7'd60, 7'd10, 1, 1, 3'd1, "fill60");
        msg(8'h90, 8'd62, 8'd20, 7'd62, 7'd20, 1, 1, 3'd2, "fill62");
        msg(8'h90, 8'd64, 8'd30, 7'd64, 7'd30, 1, 1, 3'd3, "fill64");
        msg(8'h90, 8'd65, 8'd40, 7'd65, 7'd40, 1, 1, 3'd4, "fill65");
        msg(8'h90, 8'd67, 8'd50, 7'd67, 7'd50, 1, 1, 3'd4, "full67");
        msg(8'h80, 8'd67, 8'd0,  7'd65, 7'd40, 1, 1, 3'd3, "rel67");
        msg(8'h80, 8'd65, 8'd0,  7'd64, 7'd30, 1, 1, 3'd2, "rel65");
        msg(8'h80, 8'd64, 8'd0,  7'd62, 7'd20, 1, 1, 3'd1, "rel64");
        msg(8'h80, 8'd62, 8'd0,  7'd0,  7'd0,  0, 0, 3'd0, "rel62");
        msg(8'h80, 8'd60, 8'd0,  7'd0,  7'd0,  0, 0, 3'd0, "rel60_absent");

        // Filtering and vel-0 note off
        msg(8'h90, 8'd60, 8'd100, 7'd60, 7'd100, 1, 1, 3'd1, "on60_b");
        msg(8'h90, 8'd60, 8'd0,   7'd0,  7'd0,   0, 0, 3'd0, "vel0_off");
`ifdef NOTE_STACK_OMNI_EN
        msg(8'h91, 8'd60, 8'd100, 7'd60, 7'd100, 1, 1, 3'd1, "ch1_on_omni");
        msg(8'h81, 8'd60, 8'd0,   7'd0,  7'd0,   0, 0, 3'd0, "ch1_off_omni");
        msg(8'h93, 8'd50, 8'd90,  7'd50, 7'd90,  1, 1, 3'd1, "ch3_on_omni");
        msg(8'h83, 8'd50, 8'd0,   7'd0,  7'd0,   0, 0, 3'd0, "ch3_off_omni");
`else
        msg(8'h91, 8'd60, 8'd100, 7'd0, 7'd0, 0, 0, 3'd0, "ch1_ignored");
        msg(8'h93, 8'd50, 8'd90,  7'd0, 7'd0, 0, 0, 3'd0, "ch3_ignored");
`endif
        msg(8'h90, 8'h85, 8'd64,  7'd0, 7'd0, 0, 0, 3'd0, "d1_bad");
        msg(8'h90, 8'd40, 8'h90,  7'd0, 7'd0, 0, 0, 3'd0, "d2_bad");

        // Re-strike updates velocity without a pulse; non-top release is silent
        msg(8'h90, 8'd60, 8'd100, 7'd60, 7'd100, 1, 1, 3'd1, "on60_c");
        msg(8'h90, 8'd60, 8'd50,  7'd60, 7'd50,  1, 0, 3'd1, "restrike60");
        msg(8'h90, 8'd62, 8'd70,  7'd62, 7'd70,  1, 1, 3'd2, "on62");
        msg(8'h80, 8'd60, 8'd0,   7'd62, 7'd70,  1, 0, 3'd1, "off60_lower");
        msg(8'h80, 8'd62, 8'd0,   7'd0,  7'd0,   0, 0, 3'd0, "off62");

        // Controller clears and ignored statuses
        msg(8'h90, 8'd60, 8'd1, 7'd60, 7'd1, 1, 1, 3'd1, "cc_on60");
        msg(8'h90, 8'd62, 8'd2, 7'd62, 7'd2, 1, 1, 3'd2, "cc_on62");
        msg(8'h90, 8'd64, 8'd3, 7'd64, 7'd3, 1, 1, 3'd3, "cc_on64");
        msg(8'hB0, 8'h7B, 8'd0, 7'd0,  7'd0, 0, 0, 3'd0, "all_notes_off");
        msg(8'h90, 8'd50, 8'd5, 7'd50, 7'd5, 1, 1, 3'd1, "on50");
        msg(8'hB0, 8'h07, 8'd100, 7'd50, 7'd5, 1, 0, 3'd1, "cc7_ignored");
        msg(8'hA0, 8'd50, 8'd10,  7'd50, 7'd5, 1, 0, 3'd1, "aftertouch_ign");
        msg(8'hB0, 8'h78, 8'd0,   7'd0,  7'd0, 0, 0, 3'd0, "all_sound_off");

        // Back-to-back strobes
        send(8'h90, 8'd70, 8'd1, 7'd70, 7'd1, 1, 1, 3'd1, "b2b_70");
        send(8'h90, 8'd72, 8'd2, 7'd72, 7'd2, 1, 1, 3'd2, "b2b_72");
        idle(3);

        // Full stack with a re-struck mid entry, then bottom and top releases
        msg(8'h90, 8'd74, 8'd3, 7'd74, 7'd3, 1, 1, 3'd3, "on74");
        msg(8'h90, 8'd76, 8'd4, 7'd76, 7'd4, 1, 1, 3'd4, "on76");
        msg(8'h90, 8'd72, 8'd9, 7'd72, 7'd9, 1, 1, 3'd4, "full_hit72");
        msg(8'h80, 8'd70, 8'd0, 7'd72, 7'd9, 1, 0, 3'd3, "off70_bottom");
        msg(8'h80, 8'd72, 8'd0, 7'd76, 7'd4, 1, 1, 3'd2, "off72_top");
        drain();

        // Reset while a message sits in stage 1: dropped, outputs cleared at once
        @(posedge CLK); #1;
        MIDI_STATUS = 8'h90; MIDI_DATA1 = 8'd80; MIDI_DATA2 = 8'd100; MIDI_MSG_RDY = 1'b1;
        @(posedge CLK); #1;
        MIDI_MSG_RDY = 1'b0;
        nRST = 1'b0;
        push(cyc,     7'd0, 7'd0, 1'b0, 1'b0, 3'd0, "async_reset");
        push(cyc + 1, 7'd0, 7'd0, 1'b0, 1'b0, 3'd0, "inflight_drop");
        #6 nRST = 1'b1;
        idle(3);
        msg(8'h90, 8'd61, 8'd33, 7'd61, 7'd33, 1, 1, 3'd1, "post_reset_on");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
